// File: rtl/pipeline_register_if.sv
// Handshake bundle for pipeline_register: the upstream data port, the downstream
// data port, flush control, and the status outputs.
// The producer/consumer side uses the master modport; the pipeline uses slave.
interface pipeline_register_if #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3
);
    localparam int CW = $clog2(STAGES + 1);

    logic [WIDTH-1:0] D;
    logic             DValid;
    logic             DReady;
    logic [WIDTH-1:0] Q;
    logic             QValid;
    logic             QReady;
    logic             Flush;
    logic [CW-1:0]    Count;
    logic             ParityErr;

    modport master (
        output D, DValid, QReady, Flush,
        input  DReady, Q, QValid, Count, ParityErr
    );

    modport slave (
        input  D, DValid, QReady, Flush,
        output DReady, Q, QValid, Count, ParityErr
    );
endinterface

// File: rtl/pipeline_register.sv
// Elastic STAGES-deep register pipeline with valid/ready flow control.
// Empty stages always advance, so bubbles collapse and a full pipe still moves
// one beat per cycle when the consumer is ready. Flush drops all in-flight
// beats; Count reports how many stages currently hold a beat.
// Optional feature: define PIPELINE_REGISTER_PARITY_EN to carry an even-parity
// bit with every beat and flag a mismatch on Q through ParityErr.
module pipeline_register #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3
) (
    input logic                Clock,
    input logic                Reset,
    pipeline_register_if.slave bus
);
    localparam int CW = $clog2(STAGES + 1);

    logic [STAGES-1:0] v_q;
    logic [WIDTH-1:0]  d_q [STAGES];
    logic [STAGES-1:0] adv;
    logic [CW-1:0]     count;

    // A stage may load when any stage from it to the output is empty, or the consumer takes Q.
    always_comb begin
        logic full_below;
        full_below = 1'b1;
        adv        = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            full_below = full_below & v_q[i];
            adv[i]     = !full_below || bus.QReady;
        end
    end

    // Stage registers: valids shift on advance, data loads only when a real beat moves in.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            v_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                d_q[i] <= '0;
            end
        end else if (bus.Flush) begin
            v_q <= '0;
        end else begin
            if (adv[0]) begin
                v_q[0] <= bus.DValid;
                if (bus.DValid) begin
                    d_q[0] <= bus.D;
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                if (adv[i]) begin
                    v_q[i] <= v_q[i-1];
                    if (v_q[i-1]) begin
                        d_q[i] <= d_q[i-1];
                    end
                end
            end
        end
    end

    // Occupancy is a popcount of the stage valids, so it depends on registers only.
    always_comb begin
        count = '0;
        for (int i = 0; i < STAGES; i++) begin
            count = count + CW'(v_q[i]);
        end
    end

    assign bus.DReady = adv[0] && !bus.Flush;
    assign bus.Q      = d_q[STAGES-1];
    assign bus.QValid = v_q[STAGES-1];
    assign bus.Count  = count;

`ifdef PIPELINE_REGISTER_PARITY_EN
    logic [STAGES-1:0] p_q;

    // Parity bits follow exactly the same load rules as the data words they describe.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            p_q <= '0;
        end else if (!bus.Flush) begin
            if (adv[0] && bus.DValid) begin
                p_q[0] <= ^bus.D;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (adv[i] && v_q[i-1]) begin
                    p_q[i] <= p_q[i-1];
                end
            end
        end
    end

    assign bus.ParityErr = v_q[STAGES-1] && ((^d_q[STAGES-1]) != p_q[STAGES-1]);
`else
    assign bus.ParityErr = 1'b0;
`endif
endmodule

// File: tb/tb_pipeline_register.sv
// Directed bench for pipeline_register (WIDTH=32, STAGES=3): reset, streaming,
// backpressure, full-pipe pass-through, flush, and mid-stream reset.
module tb_pipeline_register;
    localparam int WIDTH  = 32;
    localparam int STAGES = 3;

    logic Clock = 1'b0;
    logic Reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   acc;
    logic [WIDTH-1:0] exp_q;
`ifdef PIPELINE_REGISTER_PARITY_EN
    logic [STAGES-1:0] pv;
`endif

    pipeline_register_if #(.WIDTH(WIDTH), .STAGES(STAGES)) bus ();

    pipeline_register #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed no end of test, expected end of test");
        $fatal(1);
    end

    initial begin
        // Reset held two cycles while a beat is offered
        Reset      = 1'b1;
        bus.D      = '1;
        bus.DValid = 1'b1;
        bus.QReady = 1'b0;
        bus.Flush  = 1'b0;
        tick();
        tick();
        Reset      = 1'b0;
        bus.DValid = 1'b0;
        bus.D      = '0;
        settle();
        check_eq("rst_q",      64'(bus.Q),         64'h0);
        check_eq("rst_qvalid", 64'(bus.QValid),    64'h0);
        check_eq("rst_count",  64'(bus.Count),     64'h0);
        check_eq("rst_dready", 64'(bus.DReady),    64'h1);
        check_eq("rst_perr",   64'(bus.ParityErr), 64'h0);
        bus.QReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("rst_no_beat", 64'(bus.QValid), 64'h0);
        end

        // Back-to-back stream 1..8, consumer always ready
        for (int k = 0; k <= 10; k++) begin
            bus.DValid = (k < 8);
            bus.D      = WIDTH'(k + 1);
            settle();
            if (k < 8) check_eq("stream_dready", 64'(bus.DReady), 64'h1);
            tick();
            if (k >= 2 && k <= 9) begin
                check_eq("stream_qvalid", 64'(bus.QValid), 64'h1);
                check_eq("stream_q",      64'(bus.Q),      64'(k - 1));
            end else begin
                check_eq("stream_qvalid", 64'(bus.QValid), 64'h0);
            end
        end

        // Backpressure: five beats offered, only three fit
        bus.QReady = 1'b0;
        acc        = 0;
        for (int c = 0; c < 5; c++) begin
            bus.DValid = 1'b1;
            bus.D      = WIDTH'(32'h10 + acc);
            settle();
            check_eq("bp_dready", 64'(bus.DReady), 64'(acc < 3));
            if (c >= 3) begin
                check_eq("bp_hold_q",      64'(bus.Q),      64'h10);
                check_eq("bp_hold_qvalid", 64'(bus.QValid), 64'h1);
            end
            if (acc < 3) acc++;
            tick();
        end
        check_eq("bp_count", 64'(bus.Count), 64'h3);
        check_eq("bp_q",     64'(bus.Q),     64'h10);

        // Release backpressure: 0x10..0x14 emerge one per cycle
        bus.QReady = 1'b1;
        for (int j = 0; j < 5; j++) begin
            bus.DValid = (acc < 5);
            bus.D      = WIDTH'(32'h10 + acc);
            settle();
            check_eq("drain_qvalid", 64'(bus.QValid), 64'h1);
            check_eq("drain_q",      64'(bus.Q),      64'(32'h10 + j));
            if (acc < 5) begin
                check_eq("drain_dready", 64'(bus.DReady), 64'h1);
                acc++;
            end
            tick();
        end
        bus.DValid = 1'b0;
        settle();
        check_eq("drain_empty_qvalid", 64'(bus.QValid), 64'h0);
        check_eq("drain_empty_count",  64'(bus.Count),  64'h0);

        // Fill with 0x20..0x22, then pass 0xA5A5A5A5 through a full pipe
        bus.QReady = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus.DValid = 1'b1;
            bus.D      = WIDTH'(32'h20 + c);
            tick();
        end
        bus.D = 32'hA5A5A5A5;
        settle();
        check_eq("full_count",  64'(bus.Count),  64'h3);
        check_eq("full_dready", 64'(bus.DReady), 64'h0);
        bus.QReady = 1'b1;
        for (int c = 0; c < 4; c++) begin
            settle();
            exp_q = (c < 3) ? WIDTH'(32'h20 + c) : 32'hA5A5A5A5;
            check_eq("pass_dready", 64'(bus.DReady), 64'h1);
            check_eq("pass_qvalid", 64'(bus.QValid), 64'h1);
            check_eq("pass_q",      64'(bus.Q),      64'(exp_q));
            tick();
            check_eq("pass_count",  64'(bus.Count),  64'h3);
        end

        // Flush a full pipe while 0xDEADBEEF is offered
        bus.Flush  = 1'b1;
        bus.DValid = 1'b1;
        bus.D      = 32'hDEADBEEF;
        bus.QReady = 1'b0;
        settle();
        check_eq("flush_dready", 64'(bus.DReady), 64'h0);
        tick();
        bus.Flush  = 1'b0;
        bus.DValid = 1'b0;
        settle();
        check_eq("flush_qvalid", 64'(bus.QValid), 64'h0);
        check_eq("flush_count",  64'(bus.Count),  64'h0);
        check_eq("flush_q_hold", 64'(bus.Q),      64'hA5A5A5A5);
        bus.QReady = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_eq("flush_no_beat_v", 64'(bus.QValid), 64'h0);
            check_eq("flush_no_beat_q", 64'(bus.Q),      64'hA5A5A5A5);
        end

        // Two beats in flight, then reset mid-stream
        bus.QReady = 1'b0;
        bus.DValid = 1'b1;
        bus.D      = 32'h30;
        tick();
        bus.D      = 32'h31;
        tick();
        bus.DValid = 1'b0;
        tick();
        check_eq("mid_count",  64'(bus.Count),     64'h2);
        check_eq("mid_qvalid", 64'(bus.QValid),    64'h1);
        check_eq("mid_q",      64'(bus.Q),         64'h30);
        check_eq("mid_perr",   64'(bus.ParityErr), 64'h0);
`ifdef PIPELINE_REGISTER_PARITY_EN
        pv              = dut.p_q;
        pv[STAGES-1]    = ~pv[STAGES-1];
        force dut.p_q   = pv;
        settle();
        check_eq("parity_err", 64'(bus.ParityErr), 64'h1);
        release dut.p_q;
`endif
        Reset      = 1'b1;
        bus.DValid = 1'b1;
        bus.D      = 32'h77;
        tick();
        check_eq("midrst_q",      64'(bus.Q),         64'h0);
        check_eq("midrst_qvalid", 64'(bus.QValid),    64'h0);
        check_eq("midrst_count",  64'(bus.Count),     64'h0);
        check_eq("midrst_perr",   64'(bus.ParityErr), 64'h0);
        Reset      = 1'b0;
        bus.DValid = 1'b0;
        bus.QReady = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("midrst_no_beat", 64'(bus.QValid), 64'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
